// File: rtl/hex_display_ctrl.sv
// Registered multi-digit hex driver for 7-segment displays: captures a value,
// decodes 0-F per digit, applies leading-zero and blink blanking, flags updates.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_msk,
  output logic [7*NUM_DIGITS-1:0] hex_seg,
  output logic                    upd
);

  // load is a single-cycle strobe with no ready: data_in is sampled on every
  // edge where load=1 and the last captured value wins. upd rises in the same
  // cycle that hex_seg first shows the captured value.

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [4*NUM_DIGITS-1:0] data_reg;
  logic [CW-1:0]           blink_cnt;
  logic                    phase;
  logic                    load_d;
  logic [7*NUM_DIGITS-1:0] next_seg;

  // Lookup in the active-low domain, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_reg <= '0;
      load_d   <= 1'b0;
    end else begin
      if (load) data_reg <= data_in;
      load_d <= load;
    end
  end

  // Free-running blink timebase; phase flips once per BLINK_DIV cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  // Scan from the top digit down so hi_zero means "this and all higher are 0".
  always_comb begin
    logic       hi_zero;
    logic       blank;
    logic [6:0] seg;
    next_seg = '0;
    hi_zero  = 1'b1;
    blank    = 1'b0;
    seg      = 7'h7F;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (data_reg[4*i +: 4] == 4'h0);
      blank   = (lz_en && (i != 0) && hi_zero) || (phase && blink_msk[i]);
      seg     = blank ? 7'h7F : seg_lut(data_reg[4*i +: 4]);
      next_seg[7*i +: 7] = ACTIVE_LOW ? seg : ~seg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_seg <= {NUM_DIGITS{SEG_OFF}};
      upd     <= 1'b0;
    end else begin
      hex_seg <= next_seg;
      upd     <= load_d;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: 4 digits, BLINK_DIV=4, an active-low
// instance plus an active-high twin fed the same stimulus.
module tb_hex_display_ctrl;

  logic        clk;
  logic        resetn;
  logic        load;
  logic [15:0] data_in;
  logic        lz_en;
  logic [3:0]  blink_msk;
  logic [27:0] hex_seg;
  logic        upd;
  logic [27:0] hex_seg_ah;
  logic        upd_ah;

  int checks;
  int errors;
  logic [27:0] exp_q[$];

  hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .resetn(resetn), .load(load), .data_in(data_in),
    .lz_en(lz_en), .blink_msk(blink_msk), .hex_seg(hex_seg), .upd(upd)
  );

  hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(0)) u_dut_ah (
    .clk(clk), .resetn(resetn), .load(load), .data_in(data_in),
    .lz_en(lz_en), .blink_msk(blink_msk), .hex_seg(hex_seg_ah), .upd(upd_ah)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver
  task automatic do_load(input logic [15:0] v);
    load    = 1'b1;
    data_in = v;
    tick();
    load    = 1'b0;
  endtask

  function automatic logic [27:0] segs(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    logic [27:0] e;
    checks = 0;
    errors = 0;
    resetn = 1'b0; load = 1'b0; data_in = '0; lz_en = 1'b0; blink_msk = '0;

    // 1. reset
    tick(); tick();
    check("rst_seg", {4'h0, hex_seg}, 32'h0FFFFFFF);
    check("rst_upd", {31'h0, upd}, 32'h0);
    check("rst_seg_ah", {4'h0, hex_seg_ah}, 32'h0);
    resetn = 1'b1;
    tick();
    check("rel_seg", {4'h0, hex_seg}, {4'h0, segs(7'h40, 7'h40, 7'h40, 7'h40)});
    check("rel_upd", {31'h0, upd}, 32'h0);

    // 2. decode
    do_load(16'h1234);
    check("dec1_upd_early", {31'h0, upd}, 32'h0);
    tick();
    check("dec1_seg", {4'h0, hex_seg}, {4'h0, segs(7'h79, 7'h24, 7'h30, 7'h19)});
    check("dec1_upd", {31'h0, upd}, 32'h1);
    tick();
    check("dec1_upd_end", {31'h0, upd}, 32'h0);
    do_load(16'hABCD);
    tick();
    check("dec2_seg", {4'h0, hex_seg}, {4'h0, segs(7'h08, 7'h03, 7'h46, 7'h21)});
    check("dec2_upd", {31'h0, upd}, 32'h1);
    check("dec2_seg_ah", {4'h0, hex_seg_ah}, {4'h0, ~segs(7'h08, 7'h03, 7'h46, 7'h21)});
    do_load(16'hEF98);
    tick();
    check("dec3_seg", {4'h0, hex_seg}, {4'h0, segs(7'h06, 7'h0E, 7'h10, 7'h00)});

    // 3. leading-zero blanking
    lz_en = 1'b1;
    do_load(16'h0050);
    tick();
    check("lz_0050", {4'h0, hex_seg}, {4'h0, segs(7'h7F, 7'h7F, 7'h12, 7'h40)});
    do_load(16'h0000);
    tick();
    check("lz_0000", {4'h0, hex_seg}, {4'h0, segs(7'h7F, 7'h7F, 7'h7F, 7'h40)});
    do_load(16'h0607);
    tick();
    check("lz_0607", {4'h0, hex_seg}, {4'h0, segs(7'h7F, 7'h02, 7'h40, 7'h78)});
    lz_en = 1'b0;
    tick(); tick();
    check("lz_off", {4'h0, hex_seg}, {4'h0, segs(7'h40, 7'h02, 7'h40, 7'h78)});

    // 5. back-to-back loads
    exp_q.push_back(segs(7'h40, 7'h40, 7'h40, 7'h79));
    exp_q.push_back(segs(7'h40, 7'h40, 7'h40, 7'h24));
    exp_q.push_back(segs(7'h40, 7'h40, 7'h40, 7'h30));
    load = 1'b1;
    data_in = 16'h0001; tick();
    data_in = 16'h0002; tick();
    check("b2b_seg1", {4'h0, hex_seg}, {4'h0, exp_q.pop_front()});
    check("b2b_upd1", {31'h0, upd}, 32'h1);
    data_in = 16'h0003; tick();
    check("b2b_seg2", {4'h0, hex_seg}, {4'h0, exp_q.pop_front()});
    check("b2b_upd2", {31'h0, upd}, 32'h1);
    load = 1'b0; tick();
    check("b2b_seg3", {4'h0, hex_seg}, {4'h0, exp_q.pop_front()});
    check("b2b_upd3", {31'h0, upd}, 32'h1);
    tick();
    check("b2b_upd_end", {31'h0, upd}, 32'h0);

    // 4. blink: reset for a known phase, value loaded on the first edge
    resetn = 1'b0;
    #2;
    load = 1'b1; data_in = 16'h000F; blink_msk = 4'b0001; lz_en = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("blk_upd", {31'h0, upd}, 32'h1);
    check("blk_e2", {4'h0, hex_seg}, {4'h0, segs(7'h40, 7'h40, 7'h40, 7'h0E)});
    // after edge n, digit 0 is dark when ((n-1)/4) is odd
    for (int n = 3; n <= 12; n++) begin
      tick();
      e = segs(7'h40, 7'h40, 7'h40, (((n - 1) / 4) % 2 == 1) ? 7'h7F : 7'h0E);
      check($sformatf("blk_e%0d", n), {4'h0, hex_seg}, {4'h0, e});
    end

    // 6. async reset mid-blink with a load pending
    load = 1'b1; data_in = 16'h4321;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_seg", {4'h0, hex_seg}, 32'h0FFFFFFF);
    check("arst_upd", {31'h0, upd}, 32'h0);
    check("arst_seg_ah", {4'h0, hex_seg_ah}, 32'h0);
    tick();
    load = 1'b0;
    resetn = 1'b1;
    tick();
    check("arel_e1", {4'h0, hex_seg}, {4'h0, segs(7'h40, 7'h40, 7'h40, 7'h40)});
    check("arel_upd1", {31'h0, upd}, 32'h0);
    tick();
    check("arel_upd2", {31'h0, upd}, 32'h0);
    tick(); tick();
    check("arel_e4", {4'h0, hex_seg}, {4'h0, segs(7'h40, 7'h40, 7'h40, 7'h40)});
    check("arel_e4_ah", {4'h0, hex_seg_ah}, {4'h0, ~segs(7'h40, 7'h40, 7'h40, 7'h40)});
    tick();
    check("arel_e5", {4'h0, hex_seg}, {4'h0, segs(7'h40, 7'h40, 7'h40, 7'h7F)});
    check("arel_e5_ah", {4'h0, hex_seg_ah}, {4'h0, ~segs(7'h40, 7'h40, 7'h40, 7'h7F)});

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
